// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control slice: ALU op codes,
// FSM states, instruction classes, opcode constants and select encodings.
package alu_seq_ctrl_pkg;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_SLL     = 5'd2;
  localparam logic [4:0] ALU_SLT     = 5'd3;
  localparam logic [4:0] ALU_SLTU    = 5'd4;
  localparam logic [4:0] ALU_XOR     = 5'd5;
  localparam logic [4:0] ALU_SRL     = 5'd6;
  localparam logic [4:0] ALU_SRA     = 5'd7;
  localparam logic [4:0] ALU_OR      = 5'd8;
  localparam logic [4:0] ALU_AND     = 5'd9;
  localparam logic [4:0] ALU_ADD_LUI = 5'd10;
  localparam logic [4:0] ALU_ADD4    = 5'd11;
  localparam logic [4:0] ALU_BEQ     = 5'd16;
  localparam logic [4:0] ALU_BNE     = 5'd17;
  localparam logic [4:0] ALU_BLT     = 5'd18;
  localparam logic [4:0] ALU_BGE     = 5'd19;
  localparam logic [4:0] ALU_BLTU    = 5'd20;
  localparam logic [4:0] ALU_BGEU    = 5'd21;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_ZERO  = 2'd2;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_SHAMT = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } instr_cls_e;

  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [4:0] alu_arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_arith_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_arith_op = ALU_SLL;
      3'd2:    alu_arith_op = ALU_SLT;
      3'd3:    alu_arith_op = ALU_SLTU;
      3'd4:    alu_arith_op = ALU_XOR;
      3'd5:    alu_arith_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_arith_op = ALU_OR;
      default: alu_arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: ir -> ALU op, operand/immediate selects,
// instruction class and illegal-encoding flag.
module alu_seq_decode
  import alu_seq_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  alu_op,
  output logic [1:0]  src_a_sel,
  output logic [1:0]  src_b_sel,
  output logic [2:0]  imm_sel,
  output instr_cls_e  cls,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign f3            = ir[14:12];
  assign f7            = ir[31:25];
  assign unused_fields = ^ir[24:7];

  always_comb begin
    alu_op    = ALU_ADD;
    src_a_sel = SRC_A_RS1;
    src_b_sel = SRC_B_RS2;
    imm_sel   = IMM_I;
    cls       = CLS_ALU;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op  = alu_arith_op(f3, f7[5]);
        illegal = !((f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_I: begin
        // only the shift-right immediate may use funct7[5]; ADDI never subtracts
        alu_op    = alu_arith_op(f3, (f3 == 3'd5) && f7[5]);
        src_b_sel = (f3 == 3'd1 || f3 == 3'd5) ? SRC_B_SHAMT : SRC_B_IMM;
        if (f3 == 3'd1)      illegal = (f7 != F7_BASE);
        else if (f3 == 3'd5) illegal = !(f7 == F7_BASE || f7 == F7_ALT);
      end
      OP_LUI: begin
        alu_op    = ALU_ADD_LUI;
        src_a_sel = SRC_A_ZERO;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_U;
        cls       = CLS_LUI;
      end
      OP_AUIPC: begin
        src_a_sel = SRC_A_PC;
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_U;
        cls       = CLS_AUIPC;
      end
      OP_LOAD: begin
        src_b_sel = SRC_B_IMM;
        cls       = CLS_LOAD;
        illegal   = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      OP_STORE: begin
        src_b_sel = SRC_B_IMM;
        imm_sel   = IMM_S;
        cls       = CLS_STORE;
        illegal   = (f3 > 3'd2);
      end
      OP_BRANCH: begin
        imm_sel = IMM_B;
        cls     = CLS_BRANCH;
        case (f3)
          3'd0:    alu_op = ALU_BEQ;
          3'd1:    alu_op = ALU_BNE;
          3'd4:    alu_op = ALU_BLT;
          3'd5:    alu_op = ALU_BGE;
          3'd6:    alu_op = ALU_BLTU;
          3'd7:    alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: begin
        // the ALU produces the link value PC+4; the target comes from the PC adder
        alu_op    = ALU_ADD4;
        src_a_sel = SRC_A_PC;
        imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_I;
        cls       = CLS_JUMP;
        illegal   = (opcode == OP_JALR) && (f3 != 3'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define ALU_SEQ_CTRL_PERF_CNT_EN to add cycle_cnt/instret_cnt outputs.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic [31:0] ir,
  output logic [4:0]  alu_op,
  output logic [1:0]  src_a_sel,
  output logic [1:0]  src_b_sel,
  output logic [2:0]  imm_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic [31:0] pc_reset_val,
  output logic        illegal_instr
`ifdef ALU_SEQ_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e      state_reg, state_next;
  instr_cls_e  cls_reg, dec_cls;
  logic [31:0] ir_reg;
  logic [4:0]  alu_op_reg, dec_alu_op;
  logic [1:0]  src_a_reg, src_b_reg, dec_src_a, dec_src_b;
  logic [2:0]  imm_sel_reg, dec_imm_sel;
  logic        dec_illegal;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        timeout_hit;

  alu_seq_decode u_decode (
    .ir        (ir_reg),
    .alu_op    (dec_alu_op),
    .src_a_sel (dec_src_a),
    .src_b_sel (dec_src_b),
    .imm_sel   (dec_imm_sel),
    .cls       (dec_cls),
    .illegal   (dec_illegal)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == 16'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_is_fetch  = 1'b0;
    reg_we        = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    // strobes follow rst_n combinationally so a reset drops them at once
    if (rst_n) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          if (mem_ready)        state_next = ST_DECODE;
          else if (timeout_hit) state_next = ST_TRAP;
          else                  wait_cnt_next = wait_cnt_reg + 16'd1;
        end
        ST_DECODE: state_next = dec_illegal ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          case (cls_reg)
            CLS_BRANCH: begin
              pc_we      = 1'b1;
              pc_src     = alu_zero;
              state_next = ST_FETCH;
            end
            CLS_JUMP: begin
              pc_we      = 1'b1;
              pc_src     = 1'b1;
              state_next = ST_WB;
            end
            CLS_LOAD, CLS_STORE: state_next = ST_MEM;
            default:             state_next = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls_reg == CLS_STORE);
          if (mem_ready) begin
            pc_we      = (cls_reg == CLS_STORE);
            state_next = (cls_reg == CLS_STORE) ? ST_FETCH : ST_WB;
          end else if (timeout_hit) begin
            state_next = ST_TRAP;
          end else begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
          end
        end
        ST_WB: begin
          reg_we     = (ir_reg[11:7] != 5'd0);
          pc_we      = (cls_reg != CLS_JUMP);
          state_next = ST_FETCH;
        end
        ST_TRAP: state_next = ST_TRAP;
        default: state_next = ST_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_FETCH;
      ir_reg       <= '0;
      cls_reg      <= CLS_ALU;
      alu_op_reg   <= ALU_ADD;
      src_a_reg    <= SRC_A_RS1;
      src_b_reg    <= SRC_B_RS2;
      imm_sel_reg  <= IMM_I;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == ST_FETCH && mem_ready) ir_reg <= instr_in;
      if (state_reg == ST_DECODE && !dec_illegal) begin
        cls_reg     <= dec_cls;
        alu_op_reg  <= dec_alu_op;
        src_a_reg   <= dec_src_a;
        src_b_reg   <= dec_src_b;
        imm_sel_reg <= dec_imm_sel;
      end
    end
  end

  always_comb begin
    case (cls_reg)
      CLS_LOAD: wb_sel = WB_LOAD;
      CLS_JUMP: wb_sel = WB_PC4;
      default:  wb_sel = WB_ALU;
    endcase
  end

  assign ir            = ir_reg;
  assign alu_op        = alu_op_reg;
  assign src_a_sel     = src_a_reg;
  assign src_b_sel     = src_b_reg;
  assign imm_sel       = imm_sel_reg;
  assign pc_reset_val  = RESET_PC;
  assign illegal_instr = (state_reg == ST_TRAP);

`ifdef ALU_SEQ_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else if (state_reg != ST_TRAP) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      // re-entering FETCH from any later state retires one instruction
      if (state_next == ST_FETCH && state_reg != ST_FETCH)
        instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  // default build carries no performance counters
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: ALU op, branches, load/store, illegal
// opcode trap, fetch timeout trap and reset in the middle of a store.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        mem_req, mem_we, mem_is_fetch, reg_we, pc_we, pc_src, illegal_instr;
  logic [31:0] ir, pc_reset_val;
  logic [4:0]  alu_op;
  logic [1:0]  src_a_sel, src_b_sel, wb_sel;
  logic [2:0]  imm_sel;
`ifdef ALU_SEQ_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int failures = 0;

  alu_seq_ctrl #(.RESET_PC(32'h0000_0100), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_in     (instr_in),
    .mem_ready    (mem_ready),
    .alu_zero     (alu_zero),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir           (ir),
    .alu_op       (alu_op),
    .src_a_sel    (src_a_sel),
    .src_b_sel    (src_b_sel),
    .imm_sel      (imm_sel),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .pc_reset_val (pc_reset_val),
    .illegal_instr(illegal_instr)
`ifdef ALU_SEQ_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // one cycle: drive inputs at the falling edge, outputs sampled 1ns later
  task automatic step(input logic rst, input logic rdy, input logic [31:0] instr, input logic zero);
    @(negedge clk);
    rst_n     = rst;
    mem_ready = rdy;
    instr_in  = instr;
    alu_zero  = zero;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset, with mem_ready asserted to show it is ignored
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, I_ADD, 1'b0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_fetch", 32'(mem_is_fetch), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_src_a", 32'(src_a_sel), 32'd0);
    check("rst_src_b", 32'(src_b_sel), 32'd0);
    check("rst_imm", 32'(imm_sel), 32'd0);
    check("rst_wb_sel", 32'(wb_sel), 32'd0);
    check("rst_we", 32'({mem_we, reg_we, pc_we}), 32'd0);
    check("rst_illegal", 32'(illegal_instr), 32'd0);
    check("pc_reset_val", pc_reset_val, 32'h0000_0100);
    $display("txn reset checks=%0d", checks);

    // add x3,x1,x2
    step(1'b1, 1'b1, I_ADD, 1'b0);
    check("add_fetch_req", 32'({mem_req, mem_is_fetch}), 32'd3);
    step(1'b1, 1'b0, '0, 1'b0);
    check("add_ir", ir, I_ADD);
    check("add_decode_req", 32'(mem_req), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("add_exec_op", 32'(alu_op), 32'(ALU_ADD));
    check("add_exec_we", 32'({reg_we, pc_we}), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("add_wb_reg_we", 32'(reg_we), 32'd1);
    check("add_wb_pc", 32'({pc_we, pc_src}), 32'b10);
    check("add_wb_sel", 32'(wb_sel), 32'd0);
    check("add_wb_mem_we", 32'(mem_we), 32'd0);
    $display("txn add checks=%0d", checks);

    // srai x1,x1,2
    step(1'b1, 1'b1, I_SRAI, 1'b0);
    check("srai_fetch", 32'(mem_is_fetch), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("srai_op", 32'(alu_op), 32'(ALU_SRA));
    check("srai_src_b", 32'(src_b_sel), 32'd2);
    step(1'b1, 1'b0, '0, 1'b0);
    check("srai_wb_reg_we", 32'(reg_we), 32'd1);
    $display("txn srai checks=%0d", checks);

    // beq taken then not taken
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 1'b1, I_BEQ, 1'b0);
      check("beq_fetch", 32'(mem_is_fetch), 32'd1);
      step(1'b1, 1'b0, '0, 1'b0);
      check("beq_decode_reg_we", 32'(reg_we), 32'd0);
      step(1'b1, 1'b0, '0, (r == 0));
      check("beq_op", 32'(alu_op), 32'(ALU_BEQ));
      check("beq_pc_we", 32'(pc_we), 32'd1);
      check("beq_pc_src", 32'(pc_src), (r == 0) ? 32'd1 : 32'd0);
      check("beq_reg_we", 32'(reg_we), 32'd0);
      $display("txn beq zero=%0d checks=%0d", (r == 0), checks);
    end

    // lw x5,0(x1) with three wait cycles in MEM
    step(1'b1, 1'b1, I_LW, 1'b0);
    check("lw_fetch_after_beq", 32'(mem_is_fetch), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("lw_exec_op", 32'(alu_op), 32'(ALU_ADD));
    check("lw_exec_src_b", 32'(src_b_sel), 32'd1);
    check("lw_exec_mem_req", 32'(mem_req), 32'd0);
    for (int w = 0; w < 3; w++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check("lw_mem_wait", 32'({mem_req, mem_we, mem_is_fetch, pc_we}), 32'b1000);
    end
    step(1'b1, 1'b1, '0, 1'b0);
    check("lw_mem_ready", 32'({mem_req, mem_we, reg_we, pc_we}), 32'b1000);
    step(1'b1, 1'b0, '0, 1'b0);
    check("lw_wb_reg_we", 32'(reg_we), 32'd1);
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    check("lw_wb_pc_we", 32'(pc_we), 32'd1);
    $display("txn lw checks=%0d", checks);

    // sw x2,4(x1), zero-wait
    step(1'b1, 1'b1, I_SW, 1'b0);
    check("sw_fetch", 32'(mem_is_fetch), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("sw_imm_sel", 32'(imm_sel), 32'(IMM_S));
    step(1'b1, 1'b1, '0, 1'b0);
    check("sw_mem", 32'({mem_req, mem_we, mem_is_fetch}), 32'b110);
    check("sw_pc", 32'({pc_we, pc_src}), 32'b10);
    check("sw_reg_we", 32'(reg_we), 32'd0);
    $display("txn sw checks=%0d", checks);

    // sw again, reset asserted while waiting in MEM
    step(1'b1, 1'b1, I_SW, 1'b0);
    check("swr_fetch", 32'(mem_is_fetch), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("swr_mem_we", 32'({mem_req, mem_we}), 32'b11);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("swr_async_drop", 32'({mem_req, mem_we, pc_we, reg_we}), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("swr_ir_cleared", ir, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("swr_restart_fetch", 32'({mem_req, mem_is_fetch, mem_we}), 32'b110);
    $display("txn sw_reset checks=%0d", checks);

    // illegal opcode -> TRAP, sticky and silent
    step(1'b1, 1'b1, I_BAD, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("bad_decode_illegal", 32'(illegal_instr), 32'd0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, c[0], I_BAD, 1'b0);
      check("trap_flag", 32'(illegal_instr), 32'd1);
      check("trap_strobes", 32'({mem_req, mem_we, reg_we, pc_we}), 32'd0);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    check("trap_rst_clear", 32'(illegal_instr), 32'd0);
    $display("txn illegal checks=%0d", checks);

    // fetch timeout: 16 unanswered cycles, then TRAP
    for (int c = 1; c <= 16; c++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check("tmo_wait", 32'({mem_req, illegal_instr}), 32'b10);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    check("tmo_trap", 32'({mem_req, illegal_instr}), 32'b01);
    $display("txn timeout checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
